// File: rtl/task_9_out.sv
// Frame output stage: buffers NUM_WORDS words, then replays them newest-first on AXI-Stream.
// Optional macro TASK9_OUT_CHECKSUM_EN appends an XOR checksum beat to each frame.
module task_9_out #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 243
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_req,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast,
  output logic                  o_output_last
);

  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]         rd_idx_q, rd_idx_d;
  logic [DATA_WIDTH-1:0] buf_q [NUM_WORDS];
  logic                  accept;
`ifdef TASK9_OUT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic                  csum_beat_q, csum_beat_d;
`endif

  assign accept = (state_q == COLLECT) && i_data_valid;

  // Frame storage is never reset; a slot is always written before it is read.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && accept) begin
      buf_q[wr_cnt_q[AW-1:0]] <= i_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    rd_idx_d      = rd_idx_q;
    o_data_req    = 1'b0;
    o_tvalid      = 1'b0;
    o_tlast       = 1'b0;
    o_output_last = 1'b0;
    o_tdata       = '0;
`ifdef TASK9_OUT_CHECKSUM_EN
    csum_d        = csum_q;
    csum_beat_d   = csum_beat_q;
`endif
    case (state_q)
      IDLE: begin
        state_d  = COLLECT;
        wr_cnt_d = '0;
      end
      COLLECT: begin
        o_data_req = 1'b1;
        if (i_data_valid) begin
          wr_cnt_d = wr_cnt_q + CW'(1);
`ifdef TASK9_OUT_CHECKSUM_EN
          csum_d   = csum_q ^ i_data;
`endif
          if (wr_cnt_q == LAST_IDX) begin
            state_d  = DRAIN;
            rd_idx_d = LAST_IDX;
          end
        end
      end
      DRAIN: begin
        // Data and last are pure functions of registered state, so they hold during stalls.
        o_tvalid = 1'b1;
`ifdef TASK9_OUT_CHECKSUM_EN
        if (csum_beat_q) begin
          o_tdata = csum_q;
          o_tlast = 1'b1;
          if (i_tready) state_d = DONE;
        end else begin
          o_tdata = buf_q[rd_idx_q[AW-1:0]];
          if (i_tready) begin
            if (rd_idx_q == '0) csum_beat_d = 1'b1;
            else                rd_idx_d    = rd_idx_q - CW'(1);
          end
        end
`else
        o_tdata = buf_q[rd_idx_q[AW-1:0]];
        o_tlast = (rd_idx_q == '0);
        if (i_tready) begin
          if (rd_idx_q == '0) state_d  = DONE;
          else                rd_idx_d = rd_idx_q - CW'(1);
        end
`endif
      end
      DONE: begin
        o_output_last = 1'b1;
        state_d       = COLLECT;
        wr_cnt_d      = '0;
        rd_idx_d      = '0;
`ifdef TASK9_OUT_CHECKSUM_EN
        csum_d        = '0;
        csum_beat_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      rd_idx_q    <= '0;
`ifdef TASK9_OUT_CHECKSUM_EN
      csum_q      <= '0;
      csum_beat_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_idx_q    <= rd_idx_d;
`ifdef TASK9_OUT_CHECKSUM_EN
      csum_q      <= csum_d;
      csum_beat_q <= csum_beat_d;
`endif
    end
  end

endmodule

// File: tb/tb_task_9_out.sv
// Directed bench for task_9_out: three instances (4, 243 and 1 word frames) sharing one clock.
// Expectations follow TASK9_OUT_CHECKSUM_EN when the build defines it.
module tb_task_9_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n;
  logic [7:0] d;
  logic       v;
  logic       rdy;
  int         sel;

  logic [2:0] req, tv, tl, ol;
  logic [7:0] td0, td1, td2;

  task_9_out #(.DATA_WIDTH(8), .NUM_WORDS(4)) u_w4 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_data(d), .i_data_valid(v && (sel == 0)),
    .o_data_req(req[0]), .o_tdata(td0), .o_tvalid(tv[0]), .i_tready(rdy),
    .o_tlast(tl[0]), .o_output_last(ol[0]));

  task_9_out #(.DATA_WIDTH(8), .NUM_WORDS(243)) u_w243 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_data(d), .i_data_valid(v && (sel == 1)),
    .o_data_req(req[1]), .o_tdata(td1), .o_tvalid(tv[1]), .i_tready(rdy),
    .o_tlast(tl[1]), .o_output_last(ol[1]));

  task_9_out #(.DATA_WIDTH(8), .NUM_WORDS(1)) u_w1 (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_data(d), .i_data_valid(v && (sel == 2)),
    .o_data_req(req[2]), .o_tdata(td2), .o_tvalid(tv[2]), .i_tready(rdy),
    .o_tlast(tl[2]), .o_output_last(ol[2]));

  logic       m_req, m_tv, m_tl, m_ol;
  logic [7:0] m_td;
  always_comb begin
    m_req = req[0]; m_tv = tv[0]; m_tl = tl[0]; m_ol = ol[0]; m_td = td0;
    case (sel)
      1: begin m_req = req[1]; m_tv = tv[1]; m_tl = tl[1]; m_ol = ol[1]; m_td = td1; end
      2: begin m_req = req[2]; m_tv = tv[2]; m_tl = tl[2]; m_ol = ol[2]; m_td = td2; end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] expq[$];
  bit         pat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic add_csum();
`ifdef TASK9_OUT_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (expq[i]) x ^= expq[i];
    expq.push_back(x);
`endif
  endtask

  task automatic send(input string tag, input logic [7:0] w);
    chk({tag, "_req"}, m_req, 1);
    d = w;
    v = 1'b1;
    @(negedge clk);
  endtask

  // Called on the negedge right after the final accept; valid stays high to prove it is ignored.
  task automatic drain(input string tag);
    int k, cyc, n;
    k = 0; cyc = 0; n = expq.size();
    d = 8'hEE;
    chk({tag, "_req_low"}, m_req, 0);
    while (k < n && cyc < 2000) begin
      chk({tag, "_tvalid"}, m_tv, 1);
      chk({tag, "_tdata"}, m_td, expq[k]);
      chk({tag, "_tlast"}, m_tl, (k == n - 1));
      chk({tag, "_olast_early"}, m_ol, 0);
      rdy = pat[cyc % pat.size()];
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    chk({tag, "_beats"}, k, n);
    v = 1'b0;
    rdy = 1'b1;
    chk({tag, "_olast"}, m_ol, 1);
    chk({tag, "_done_tvalid"}, m_tv, 0);
    chk({tag, "_done_req"}, m_req, 0);
    @(negedge clk);
    chk({tag, "_olast_pulse"}, m_ol, 0);
    chk({tag, "_req_again"}, m_req, 1);
  endtask

  initial begin
    int i, cyc;
    rst_n = 3'b000; d = 8'h00; v = 1'b0; rdy = 1'b1; sel = 0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k; #1;
      chk("rst_req", m_req, 0);
      chk("rst_tvalid", m_tv, 0);
      chk("rst_tlast", m_tl, 0);
      chk("rst_olast", m_ol, 0);
      chk("rst_tdata", m_td, 0);
    end
    @(negedge clk);
    rst_n = 3'b111;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k; #1;
      chk("post_rst_req", m_req, 1);
    end
    sel = 0;
    @(negedge clk);

    // 4-word frame, ready always high
    send("s1", 8'h11); send("s1", 8'h22); send("s1", 8'h33); send("s1", 8'h44);
    expq = '{8'h44, 8'h33, 8'h22, 8'h11}; add_csum();
    pat = '{1'b1};
    drain("s1");

    // same frame with downstream stalls
    send("s2", 8'h11); send("s2", 8'h22); send("s2", 8'h33); send("s2", 8'h44);
    expq = '{8'h44, 8'h33, 8'h22, 8'h11}; add_csum();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    drain("s2");

    // reset after two words discards the partial frame
    send("s4", 8'h11); send("s4", 8'h22);
    rst_n[0] = 1'b0; v = 1'b0;
    @(negedge clk);
    chk("s4_rst_req", m_req, 0);
    chk("s4_rst_tvalid", m_tv, 0);
    chk("s4_rst_tlast", m_tl, 0);
    chk("s4_rst_olast", m_ol, 0);
    chk("s4_rst_tdata", m_td, 0);
    rst_n[0] = 1'b1;
    @(negedge clk);
    chk("s4_req_rerise", m_req, 1);
    chk("s4_tvalid_idle", m_tv, 0);
    send("s4", 8'hA0); send("s4", 8'hA1); send("s4", 8'hA2); send("s4", 8'hA3);
    expq = '{8'hA3, 8'hA2, 8'hA1, 8'hA0}; add_csum();
    pat = '{1'b1};
    drain("s4");

    // checksum pattern (plain reversed frame when the checksum beat is not built)
    send("s5", 8'h01); send("s5", 8'h02); send("s5", 8'h04); send("s5", 8'h08);
    expq = '{8'h08, 8'h04, 8'h02, 8'h01}; add_csum();
    pat = '{1'b1};
    drain("s5");

    // 243-word frame with a valid gap every third cycle
    sel = 1;
    i = 0; cyc = 0;
    while (i < 243 && cyc < 1000) begin
      chk("s3_req", m_req, 1);
      v = ((cyc % 3) != 2);
      d = 8'(i);
      @(negedge clk);
      if (v) i++;
      cyc++;
    end
    chk("s3_accepts", i, 243);
    expq = {};
    for (int k = 242; k >= 0; k--) expq.push_back(8'(k));
    add_csum();
    pat = '{1'b1};
    drain("s3");

    // single-word frame
    sel = 2;
    send("s6", 8'h5A);
    expq = '{8'h5A}; add_csum();
    pat = '{1'b1};
    drain("s6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
